// File: rtl/instruction_memory_if.sv
// rtl/instruction_memory_if.sv - loader and fetch bus for the instruction memory
interface instruction_memory_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  load_start;
  logic [ADDR_WIDTH-1:0] load_base;
  logic [ADDR_WIDTH:0]   load_len;
  logic                  wr_valid;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;
  logic                  load_done;
  logic                  busy;
  logic                  en;
  logic [ADDR_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] instr;
  logic                  instr_valid;

  modport master (
    output load_start, load_base, load_len, wr_valid, wr_data, en, pc,
    input  wr_ready, load_done, busy, instr, instr_valid
  );

  modport slave (
    input  load_start, load_base, load_len, wr_valid, wr_data, en, pc,
    output wr_ready, load_done, busy, instr, instr_valid
  );
endinterface

// File: rtl/instruction_memory.sv
// rtl/instruction_memory.sv - loadable instruction memory with 1-cycle fetch port
module instruction_memory #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  instruction_memory_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LP_COUNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] LP_COUNT_ZERO = '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_instr;
  logic                  r_instr_valid;
  logic                  r_load_done;
  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

  logic w_busy;
  logic w_wr_ready;
  logic w_can_start;
  logic w_start;
  logic w_start_zero;
  logic w_beat;
  logic w_last_beat;
  logic w_fetch;
  logic w_done_evt;

  // load_start is only honoured outside LOAD and always wins over a fetch
  assign w_can_start  = (r_state == S_IDLE) || (r_state == S_READY);
  assign w_start      = w_can_start && bus.load_start && (bus.load_len != LP_COUNT_ZERO);
  assign w_start_zero = w_can_start && bus.load_start && (bus.load_len == LP_COUNT_ZERO);
  assign w_beat       = w_wr_ready && bus.wr_valid;
  assign w_last_beat  = w_beat && (r_count == LP_COUNT_ONE);
  assign w_fetch      = (r_state == S_READY) && bus.en && !bus.load_start;
  assign w_done_evt   = w_start_zero || w_last_beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_READY: begin
        if (w_start) begin
          w_next_state = S_LOAD;
        end else if (w_start_zero) begin
          w_next_state = S_READY;
        end
      end
      S_LOAD: begin
        if (w_last_beat) begin
          w_next_state = S_READY;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy     = 1'b0;
    w_wr_ready = 1'b0;
    if (r_state == S_LOAD) begin
      w_busy     = 1'b1;
      w_wr_ready = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr        <= '0;
      r_count       <= '0;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_load_done   <= 1'b0;
    end else begin
      r_load_done <= w_done_evt;
      if (w_start) begin
        r_addr        <= bus.load_base;
        r_count       <= bus.load_len;
        r_instr_valid <= 1'b0;
      end else if (w_beat) begin
        r_addr  <= r_addr + 1'b1;
        r_count <= r_count - 1'b1;
      end else if (w_fetch) begin
        r_instr       <= r_mem[bus.pc];
        r_instr_valid <= 1'b1;
      end
    end
  end

  // Storage is intentionally left out of reset so it maps onto plain RAM
  always_ff @(posedge clk) begin
    if (w_beat) begin
      r_mem[r_addr] <= bus.wr_data;
    end
  end

  assign bus.busy        = w_busy;
  assign bus.wr_ready    = w_wr_ready;
  assign bus.load_done   = r_load_done;
  assign bus.instr       = r_instr;
  assign bus.instr_valid = r_instr_valid;
endmodule

// File: tb/tb_instruction_memory.sv
// tb/tb_instruction_memory.sv - directed self-checking bench for instruction_memory
module tb_instruction_memory;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;

  instruction_memory_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

  instruction_memory #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [7:0] base, input logic [8:0] len);
    bus.load_start = 1'b1;
    bus.load_base  = base;
    bus.load_len   = len;
    tick();
    bus.load_start = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic [7:0] a, input logic [31:0] exp);
    bus.en = 1'b1;
    bus.pc = a;
    tick();
    bus.en = 1'b0;
    chk({tag, "_instr"}, bus.instr, exp);
    chk({tag, "_valid"}, bus.instr_valid, 1'b1);
  endtask

  logic [6:0] pat;

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n          = 1'b1;
    bus.load_start = 1'b0;
    bus.load_base  = '0;
    bus.load_len   = '0;
    bus.wr_valid   = 1'b0;
    bus.wr_data    = '0;
    bus.en         = 1'b0;
    bus.pc         = '0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_wr_ready", bus.wr_ready, 1'b0);
    chk("rst_load_done", bus.load_done, 1'b0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_valid", bus.instr_valid, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // base 0 len 4 with continuous beats
    start_load(8'h00, 9'd4);
    chk("l4_busy", bus.busy, 1'b1);
    bus.wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("l4_wr_ready%0d", i), bus.wr_ready, 1'b1);
      chk($sformatf("l4_done_early%0d", i), bus.load_done, 1'b0);
      bus.wr_data = 32'hA0 + i;
      tick();
    end
    bus.wr_valid = 1'b0;
    chk("l4_done", bus.load_done, 1'b1);
    chk("l4_busy_after", bus.busy, 1'b0);
    chk("l4_wr_ready_after", bus.wr_ready, 1'b0);
    chk("l4_valid_before_fetch", bus.instr_valid, 1'b0);
    tick();
    chk("l4_done_one_cycle", bus.load_done, 1'b0);

    // fetch then stall
    fetch("f2", 8'h02, 32'hA2);
    bus.pc = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall%0d_instr", i), bus.instr, 32'hA2);
      chk($sformatf("stall%0d_valid", i), bus.instr_valid, 1'b1);
    end

    // wrap-around load at the top of the address space
    start_load(8'hFE, 9'd3);
    chk("wrap_valid_cleared", bus.instr_valid, 1'b0);
    chk("wrap_instr_held", bus.instr, 32'hA2);
    bus.en = 1'b1;
    bus.pc = 8'h01;
    bus.wr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.wr_data = 32'h11 * (i + 1);
      tick();
    end
    bus.wr_valid = 1'b0;
    bus.en = 1'b0;
    chk("wrap_done", bus.load_done, 1'b1);
    chk("wrap_no_fetch_in_load", bus.instr, 32'hA2);
    fetch("wrapFE", 8'hFE, 32'h11);
    fetch("wrapFF", 8'hFF, 32'h22);
    fetch("wrap00", 8'h00, 32'h33);
    fetch("keep01", 8'h01, 32'hA1);

    // gapped beats: only the valid cycles write
    pat = 7'b1011001;
    start_load(8'h10, 9'd4);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("gap_busy%0d", i), bus.busy, 1'b1);
      bus.wr_valid = pat[i];
      bus.wr_data  = 32'hB0 + i;
      tick();
      if (i < 6) chk($sformatf("gap_done_early%0d", i), bus.load_done, 1'b0);
    end
    bus.wr_valid = 1'b0;
    chk("gap_done", bus.load_done, 1'b1);
    fetch("gap10", 8'h10, 32'hB0);
    fetch("gap11", 8'h11, 32'hB3);
    fetch("gap12", 8'h12, 32'hB4);
    fetch("gap13", 8'h13, 32'hB6);

    // zero-length load
    start_load(8'h80, 9'd0);
    chk("zl_done", bus.load_done, 1'b1);
    chk("zl_wr_ready", bus.wr_ready, 1'b0);
    chk("zl_busy", bus.busy, 1'b0);
    tick();
    chk("zl_done_one_cycle", bus.load_done, 1'b0);
    chk("zl_wr_ready_after", bus.wr_ready, 1'b0);

    // load_start during LOAD must not retarget or reload the count
    start_load(8'h20, 9'd2);
    bus.wr_valid   = 1'b1;
    bus.wr_data    = 32'hC0;
    bus.load_start = 1'b1;
    bus.load_base  = 8'h30;
    bus.load_len   = 9'd5;
    tick();
    bus.load_start = 1'b0;
    bus.wr_data    = 32'hC1;
    tick();
    bus.wr_valid = 1'b0;
    chk("ign_done", bus.load_done, 1'b1);
    chk("ign_busy", bus.busy, 1'b0);
    fetch("ign20", 8'h20, 32'hC0);
    fetch("ign21", 8'h21, 32'hC1);

    // reset in the middle of a load
    start_load(8'h40, 9'd4);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 32'hD0;
    tick();
    bus.wr_data  = 32'hD1;
    tick();
    bus.wr_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_wr_ready", bus.wr_ready, 1'b0);
    chk("abort_load_done", bus.load_done, 1'b0);
    chk("abort_instr", bus.instr, 32'h0);
    chk("abort_valid", bus.instr_valid, 1'b0);
    tick();
    rst_n = 1'b1;
    bus.en = 1'b1;
    bus.pc = 8'h40;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("idle_valid%0d", i), bus.instr_valid, 1'b0);
      chk($sformatf("idle_done%0d", i), bus.load_done, 1'b0);
    end
    bus.en = 1'b0;
    start_load(8'h00, 9'd0);
    fetch("kept40", 8'h40, 32'hD0);
    fetch("kept41", 8'h41, 32'hD1);

    // load_start with en in READY: the load wins, no read happens
    bus.en = 1'b1;
    bus.pc = 8'h40;
    start_load(8'h50, 9'd1);
    bus.en = 1'b0;
    chk("prio_instr", bus.instr, 32'hD1);
    chk("prio_valid", bus.instr_valid, 1'b0);
    chk("prio_busy", bus.busy, 1'b1);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 32'hE0;
    tick();
    bus.wr_valid = 1'b0;
    chk("prio_done", bus.load_done, 1'b1);
    fetch("prio50", 8'h50, 32'hE0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
